// File: rtl/am_lock_ctrl_if.sv
// Lane-framer strobes and lock/error status between the lane framers and am_lock_ctrl.
interface am_lock_ctrl_if #(
    parameter int N_LANES = 16
);
    logic [N_LANES-1:0] sync_lane;
    logic [N_LANES-1:0] am_match;
    logic               clr_err;
    logic [N_LANES-1:0] lane_locked;
    logic               all_locked;
    logic               check_en;
    logic [N_LANES-1:0] lane_error;
    logic               skew_error;

    modport master (
        output sync_lane, am_match, clr_err,
        input  lane_locked, all_locked, check_en, lane_error, skew_error
    );

    modport slave (
        input  sync_lane, am_match, clr_err,
        output lane_locked, all_locked, check_en, lane_error, skew_error
    );
endinterface

// File: rtl/am_lock_ctrl.sv
// Per-lane alignment-marker lock supervisor (HUNT/CONFIRM/LOCKED) with sticky errors.
// Optional inter-lane skew checking is built only when AM_LOCK_SKEW_CHECK_EN is defined.
module am_lock_ctrl #(
    parameter int N_LANES   = 16,
    parameter int AM_PERIOD = 8192,
    parameter int LOCK_GOOD = 2,
    parameter int MISS_MAX  = 3,
    parameter int MAX_SKEW  = 4
) (
    input logic            clk,
    input logic            rst,
    am_lock_ctrl_if.slave  bus
);
    localparam int PW = $clog2(AM_PERIOD);
    localparam int GW = $clog2(LOCK_GOOD + 1);
    localparam int MW = $clog2(MISS_MAX + 1);
    localparam logic [PW-1:0] LAST = PW'(AM_PERIOD - 1);

    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] CONFIRM = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    logic [1:0]    state_q [N_LANES];
    logic [1:0]    state_d [N_LANES];
    logic [PW-1:0] phase_q [N_LANES];
    logic [PW-1:0] phase_d [N_LANES];
    logic [GW-1:0] good_q  [N_LANES];
    logic [GW-1:0] good_d  [N_LANES];
    logic [MW-1:0] miss_q  [N_LANES];
    logic [MW-1:0] miss_d  [N_LANES];

    logic [N_LANES-1:0] good_ev;
    logic [N_LANES-1:0] slot;
    logic [N_LANES-1:0] err_set;
    logic [N_LANES-1:0] locked_d;
    logic [N_LANES-1:0] lane_locked_q;
    logic [N_LANES-1:0] lane_error_q;
    logic               all_locked_q;
    logic               check_en_q;

    assign good_ev = bus.sync_lane & bus.am_match;

    always_comb begin
        for (int unsigned i = 0; i < N_LANES; i++) begin
            state_d[i]  = state_q[i];
            phase_d[i]  = phase_q[i];
            good_d[i]   = good_q[i];
            miss_d[i]   = miss_q[i];
            err_set[i]  = 1'b0;
            slot[i]     = (phase_q[i] == LAST);
            locked_d[i] = 1'b0;

            case (state_q[i])
                HUNT: begin
                    phase_d[i] = '0;
                    if (good_ev[i]) begin
                        state_d[i] = CONFIRM;
                        good_d[i]  = '0;
                    end
                end
                CONFIRM: begin
                    phase_d[i] = slot[i] ? '0 : phase_q[i] + 1'b1;
                    if (slot[i]) begin
                        if (good_ev[i]) begin
                            good_d[i] = good_q[i] + 1'b1;
                            if (good_q[i] + 1'b1 == GW'(LOCK_GOOD)) begin
                                state_d[i] = LOCKED;
                                miss_d[i]  = '0;
                            end
                        end else begin
                            state_d[i] = HUNT;
                            phase_d[i] = '0;
                        end
                    end else if (bus.sync_lane[i]) begin
                        state_d[i] = HUNT;
                        phase_d[i] = '0;
                    end
                end
                LOCKED: begin
                    phase_d[i] = slot[i] ? '0 : phase_q[i] + 1'b1;
                    if (slot[i]) begin
                        if (good_ev[i]) begin
                            miss_d[i] = '0;
                        end else if (miss_q[i] + 1'b1 == MW'(MISS_MAX)) begin
                            state_d[i] = HUNT;
                            phase_d[i] = '0;
                            miss_d[i]  = '0;
                            err_set[i] = 1'b1;
                        end else begin
                            miss_d[i] = miss_q[i] + 1'b1;
                        end
                    end else if (bus.sync_lane[i]) begin
                        // Stray strobe while locked is flagged but does not disturb alignment
                        err_set[i] = 1'b1;
                    end
                end
                default: begin
                    state_d[i] = HUNT;
                    phase_d[i] = '0;
                end
            endcase

            locked_d[i] = (state_d[i] == LOCKED);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
                state_q[i] <= HUNT;
                phase_q[i] <= '0;
                good_q[i]  <= '0;
                miss_q[i]  <= '0;
            end
            lane_locked_q <= '0;
            lane_error_q  <= '0;
            all_locked_q  <= 1'b0;
            check_en_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
                state_q[i] <= state_d[i];
                phase_q[i] <= phase_d[i];
                good_q[i]  <= good_d[i];
                miss_q[i]  <= miss_d[i];
            end
            lane_locked_q <= locked_d;
            // Set beats clear when both land in the same cycle
            lane_error_q  <= err_set | (bus.clr_err ? '0 : lane_error_q);
            all_locked_q  <= &lane_locked_q;
            check_en_q    <= all_locked_q;
        end
    end

    assign bus.lane_locked = lane_locked_q;
    assign bus.lane_error  = lane_error_q;
    assign bus.all_locked  = all_locked_q;
    assign bus.check_en    = check_en_q;

`ifdef AM_LOCK_SKEW_CHECK_EN
    logic skew_viol;
    logic skew_error_q;

    // Lane 0 wrapping to zero is the reference instant; every lane must sit within the window
    always_comb begin
        skew_viol = 1'b0;
        if (all_locked_q && phase_q[0] == '0) begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
                if (!(phase_q[i] <= PW'(MAX_SKEW) ||
                      phase_q[i] >= PW'(AM_PERIOD - MAX_SKEW))) begin
                    skew_viol = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skew_error_q <= 1'b0;
        end else if (skew_viol) begin
            skew_error_q <= 1'b1;
        end else if (bus.clr_err) begin
            skew_error_q <= 1'b0;
        end
    end

    assign bus.skew_error = skew_error_q;
`else
    assign bus.skew_error = 1'b0;
`endif
endmodule

// File: tb/tb_am_lock_ctrl.sv
// Scoreboard bench for am_lock_ctrl: expectations are queued with a target cycle when
// stimulus is driven and compared on the falling edge of that cycle.
module tb_am_lock_ctrl;
    localparam int P = 32;
    localparam logic [15:0] ALL = 16'hFFFF;
    localparam logic [15:0] B3  = 16'h0008;
    localparam logic [15:0] B5  = 16'h0020;
    localparam logic [15:0] B7  = 16'h0080;
    localparam logic [15:0] B9  = 16'h0200;
`ifdef AM_LOCK_SKEW_CHECK_EN
    localparam logic [15:0] SKEW6_EXP = 16'h0001;
`else
    localparam logic [15:0] SKEW6_EXP = 16'h0000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        string       tag;
        int          cyc;
        int          sel;
        logic [15:0] exp;
    } exp_t;
    exp_t sb[$];

    am_lock_ctrl_if #(.N_LANES(16)) bus ();

    am_lock_ctrl #(
        .N_LANES  (16),
        .AM_PERIOD(P),
        .LOCK_GOOD(2),
        .MISS_MAX (3),
        .MAX_SKEW (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] out_val(input int sel);
        case (sel)
            0:       return bus.lane_locked;
            1:       return {15'b0, bus.all_locked};
            2:       return {15'b0, bus.check_en};
            3:       return bus.lane_error;
            default: return {15'b0, bus.skew_error};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].cyc == cyc) begin
                check(sb[k].tag, out_val(sb[k].sel), sb[k].exp);
                sb.delete(k);
            end
        end
    end

    task automatic expect_at(input string tag, input int sel, input logic [15:0] exp, input int d);
        exp_t e;
        e.tag = tag;
        e.cyc = cyc + d;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [15:0] s, input logic [15:0] m, input logic c);
        bus.sync_lane = s;
        bus.am_match  = m;
        bus.clr_err   = c;
        tick(1);
        bus.sync_lane = '0;
        bus.am_match  = '0;
        bus.clr_err   = 1'b0;
    endtask

    // Lock all lanes with lane 9 trailing the others by 'off' cycles, then inspect skew
    task automatic lock_offset(input int off, input logic [15:0] skew_exp, input string tag);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        for (int r = 0; r < 4; r++) begin
            pulse(~B9, ~B9, 1'b0);
            if (off > 1) tick(off - 1);
            pulse(B9, B9, 1'b0);
            tick(P - off - 1);
        end
        expect_at({tag, "_all"}, 1, 16'h0001, 0);
        expect_at(tag, 4, skew_exp, 0);
        tick(1);
    endtask

    initial begin
        bus.sync_lane = '0;
        bus.am_match  = '0;
        bus.clr_err   = 1'b0;
        tick(2);
        check("rst_lane_locked", bus.lane_locked, 16'h0000);
        check("rst_all_locked", {15'b0, bus.all_locked}, 16'h0000);
        check("rst_check_en", {15'b0, bus.check_en}, 16'h0000);
        check("rst_lane_error", bus.lane_error, 16'h0000);
        check("rst_skew_error", {15'b0, bus.skew_error}, 16'h0000);
        rst = 1'b0;
        tick(3);

        // Acquisition, with an early strobe on lane 5 while confirming
        pulse(ALL, ALL, 1'b0);
        tick(10);
        expect_at("confirm_sync_noerr", 3, 16'h0000, 1);
        pulse(B5, B5, 1'b0);
        tick(P - 12);
        expect_at("confirm_not_locked", 0, 16'h0000, 1);
        pulse(ALL, ALL, 1'b0);
        tick(P - 1);
        expect_at("locked_without_5", 0, 16'hFFDF, 1);
        expect_at("all_locked_wait", 1, 16'h0000, 2);
        pulse(ALL, ALL, 1'b0);
        tick(P - 1);
        expect_at("lock_pre", 0, 16'hFFDF, 0);
        expect_at("lock_all_lanes", 0, ALL, 1);
        expect_at("check_en_wait", 2, 16'h0000, 2);
        expect_at("all_locked_rise", 1, 16'h0001, 2);
        expect_at("check_en_rise", 2, 16'h0001, 3);
        pulse(ALL, ALL, 1'b0);

        // Stray strobe on a locked lane
        tick(10);
        expect_at("locked_sync_err", 3, B5, 1);
        expect_at("locked_sync_hold", 0, ALL, 1);
        pulse(B5, 16'h0000, 1'b0);
        tick(P - 12);

        // Three missed markers on lane 3
        pulse(ALL, ~B3, 1'b0);
        tick(P - 1);
        expect_at("miss2_hold", 0, ALL, 1);
        pulse(ALL, ~B3, 1'b0);
        tick(P - 1);
        expect_at("miss3_drop", 0, 16'hFFF7, 1);
        expect_at("miss3_err", 3, 16'h0028, 1);
        expect_at("miss3_all_locked", 1, 16'h0000, 2);
        expect_at("miss3_cen_hold", 2, 16'h0001, 2);
        expect_at("miss3_cen_drop", 2, 16'h0000, 3);
        pulse(ALL, ~B3, 1'b0);

        // Clear racing a new error on lane 7, then a lone clear
        tick(10);
        expect_at("clr_race", 3, B7, 1);
        pulse(B7, 16'h0000, 1'b1);
        expect_at("clr_only", 3, 16'h0000, 1);
        pulse(16'h0000, 16'h0000, 1'b1);
        tick(2);

        lock_offset(6, SKEW6_EXP, "skew6");
        lock_offset(4, 16'h0000, "skew4");

        // Asynchronous reset while fully locked, then full re-acquisition
        check("pre_rst_all_locked", {15'b0, bus.all_locked}, 16'h0001);
        rst = 1'b1;
        #1;
        check("async_rst_lane_locked", bus.lane_locked, 16'h0000);
        check("async_rst_all_locked", {15'b0, bus.all_locked}, 16'h0000);
        check("async_rst_check_en", {15'b0, bus.check_en}, 16'h0000);
        check("async_rst_lane_error", bus.lane_error, 16'h0000);
        check("async_rst_skew_error", {15'b0, bus.skew_error}, 16'h0000);
        tick(1);
        rst = 1'b0;
        tick(2);
        expect_at("relock1", 0, 16'h0000, 1);
        pulse(ALL, ALL, 1'b0);
        tick(P - 1);
        expect_at("relock2", 0, 16'h0000, 1);
        pulse(ALL, ALL, 1'b0);
        tick(P - 1);
        expect_at("relock3", 0, ALL, 1);
        expect_at("relock_all", 1, 16'h0001, 2);
        expect_at("relock_cen", 2, 16'h0001, 3);
        pulse(ALL, ALL, 1'b0);

        for (int w = 0; w < 8 && sb.size() > 0; w++) tick(1);
        check("sb_drain", 16'(sb.size()), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
